// File: rtl/lz4_buf_rd_arbiter.sv
// Round-robin arbiter for the single read port of the LZ4 sliding-window buffer.
// Only one transaction is in flight; the pointer is held until read data returns.
module lz4_buf_rd_arbiter #(
  parameter int TIMEOUT = 8,
  parameter int PTR_W   = 16
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             req0,
  input  logic [PTR_W-1:0] ptr0,
  output logic             gnt0,
  output logic [31:0]      data0,
  output logic             dvalid0,
  input  logic             req1,
  input  logic [PTR_W-1:0] ptr1,
  output logic             gnt1,
  output logic [31:0]      data1,
  output logic             dvalid1,
  output logic             abort,
  output logic             abort_id,
  output logic             timeout_err,
  input  logic             buf_unable,
  output logic             buf_rdreq,
  output logic [PTR_W-1:0] buf_rdpointer,
  input  logic [31:0]      buf_odata,
  input  logic             buf_ovalid
);

  localparam int TMO_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t             r_state, w_state;
  logic               r_owner, w_owner;
  logic               r_rr_last, w_rr_last;
  logic               r_rdreq, w_rdreq;
  logic [PTR_W-1:0]   r_rdptr, w_rdptr;
  logic               r_gnt0, w_gnt0, r_gnt1, w_gnt1;
  logic               r_dv0, w_dv0, r_dv1, w_dv1;
  logic [31:0]        r_d0, w_d0, r_d1, w_d1;
  logic               r_abort, w_abort;
  logic               r_abort_id, w_abort_id;
  logic               r_terr, w_terr;
  logic [TMO_W-1:0]   r_tmo, w_tmo;
  logic               w_win;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_state    <= S_IDLE;
      r_owner    <= 1'b0;
      r_rr_last  <= 1'b1;
      r_rdreq    <= 1'b0;
      r_rdptr    <= '0;
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_dv0      <= 1'b0;
      r_dv1      <= 1'b0;
      r_d0       <= '0;
      r_d1       <= '0;
      r_abort    <= 1'b0;
      r_abort_id <= 1'b0;
      r_terr     <= 1'b0;
      r_tmo      <= '0;
    end else begin
      r_state    <= w_state;
      r_owner    <= w_owner;
      r_rr_last  <= w_rr_last;
      r_rdreq    <= w_rdreq;
      r_rdptr    <= w_rdptr;
      r_gnt0     <= w_gnt0;
      r_gnt1     <= w_gnt1;
      r_dv0      <= w_dv0;
      r_dv1      <= w_dv1;
      r_d0       <= w_d0;
      r_d1       <= w_d1;
      r_abort    <= w_abort;
      r_abort_id <= w_abort_id;
      r_terr     <= w_terr;
      r_tmo      <= w_tmo;
    end
  end

  // Outputs are registered, so every value here appears one cycle later.
  always_comb begin
    w_state    = r_state;
    w_owner    = r_owner;
    w_rr_last  = r_rr_last;
    w_rdreq    = 1'b0;
    w_rdptr    = r_rdptr;
    w_gnt0     = 1'b0;
    w_gnt1     = 1'b0;
    w_dv0      = 1'b0;
    w_dv1      = 1'b0;
    w_d0       = r_d0;
    w_d1       = r_d1;
    w_abort    = 1'b0;
    w_abort_id = r_abort_id;
    w_terr     = r_terr;
    w_tmo      = r_tmo;
    w_win      = (req0 & req1) ? ~r_rr_last : req1;
    case (r_state)
      S_IDLE: begin
        w_rdptr = '0;
        if (!buf_unable && (req0 | req1)) begin
          w_owner = w_win;
          w_rdptr = w_win ? ptr1 : ptr0;
          w_gnt0  = ~w_win;
          w_gnt1  = w_win;
          w_rdreq = 1'b1;
          w_tmo   = '0;
          w_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_rr_last = r_owner;
        w_tmo     = r_tmo + 1'b1;
        w_state   = S_WAIT;
      end
      S_WAIT: begin
        w_tmo = r_tmo + 1'b1;
        // Returned data beats a simultaneous clear, which beats the timeout.
        if (buf_ovalid) begin
          if (r_owner) begin
            w_d1  = buf_odata;
            w_dv1 = 1'b1;
          end else begin
            w_d0  = buf_odata;
            w_dv0 = 1'b1;
          end
          w_rdptr = '0;
          w_state = S_IDLE;
        end else if (buf_unable) begin
          w_abort    = 1'b1;
          w_abort_id = r_owner;
          w_rdptr    = '0;
          w_state    = S_IDLE;
        end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
          w_abort    = 1'b1;
          w_abort_id = r_owner;
          w_terr     = 1'b1;
          w_rdptr    = '0;
          w_state    = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign gnt0          = r_gnt0;
  assign gnt1          = r_gnt1;
  assign data0         = r_d0;
  assign data1         = r_d1;
  assign dvalid0       = r_dv0;
  assign dvalid1       = r_dv1;
  assign abort         = r_abort;
  assign abort_id      = r_abort_id;
  assign timeout_err   = r_terr;
  assign buf_rdreq     = r_rdreq;
  assign buf_rdpointer = r_rdptr;

endmodule

// File: tb/tb_lz4_buf_rd_arbiter.sv
// Directed bench for lz4_buf_rd_arbiter; the buffer is played cycle by cycle.
module tb_lz4_buf_rd_arbiter;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [15:0] ptr0 = '0, ptr1 = '0;
  logic        gnt0, gnt1, dvalid0, dvalid1, abort, abort_id, timeout_err;
  logic [31:0] data0, data1;
  logic        buf_unable = 1'b0, buf_rdreq, buf_ovalid = 1'b0;
  logic [15:0] buf_rdpointer;
  logic [31:0] buf_odata = '0;

  int total = 0;
  int bad   = 0;

  lz4_buf_rd_arbiter #(.TIMEOUT(8), .PTR_W(16)) dut (
    .clk(clk), .rstN(rstN),
    .req0(req0), .ptr0(ptr0), .gnt0(gnt0), .data0(data0), .dvalid0(dvalid0),
    .req1(req1), .ptr1(ptr1), .gnt1(gnt1), .data1(data1), .dvalid1(dvalid1),
    .abort(abort), .abort_id(abort_id), .timeout_err(timeout_err),
    .buf_unable(buf_unable), .buf_rdreq(buf_rdreq), .buf_rdpointer(buf_rdpointer),
    .buf_odata(buf_odata), .buf_ovalid(buf_ovalid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".gnt"},   {30'd0, gnt1, gnt0}, 32'd0);
    chk({tag, ".dv"},    {30'd0, dvalid1, dvalid0}, 32'd0);
    chk({tag, ".data0"}, data0, 32'd0);
    chk({tag, ".data1"}, data1, 32'd0);
    chk({tag, ".abort"}, {30'd0, abort, abort_id}, 32'd0);
    chk({tag, ".terr"},  {31'd0, timeout_err}, 32'd0);
    chk({tag, ".rdreq"}, {31'd0, buf_rdreq}, 32'd0);
    chk({tag, ".rdptr"}, {16'd0, buf_rdpointer}, 32'd0);
  endtask

  initial begin
    // reset
    tick(); tick();
    chk_all_zero("rst");
    rstN = 1'b1;
    tick();

    // aligned single read by requester 0
    req0 = 1'b1; ptr0 = 16'h0010;
    tick();                                   // cycle 1
    chk("al.gnt0", {31'd0, gnt0}, 32'd1);
    chk("al.gnt1", {31'd0, gnt1}, 32'd0);
    chk("al.rdreq", {31'd0, buf_rdreq}, 32'd1);
    chk("al.ptr1", {16'd0, buf_rdpointer}, 32'h0010);
    req0 = 1'b0;
    tick();                                   // cycle 2
    chk("al.rdreq2", {31'd0, buf_rdreq}, 32'd0);
    chk("al.ptr2", {16'd0, buf_rdpointer}, 32'h0010);
    buf_ovalid = 1'b1; buf_odata = 32'hA1B2C3D4;
    tick();                                   // cycle 3
    buf_ovalid = 1'b0;
    chk("al.dv0", {31'd0, dvalid0}, 32'd1);
    chk("al.dv1", {31'd0, dvalid1}, 32'd0);
    chk("al.data0", data0, 32'hA1B2C3D4);
    chk("al.ptr3", {16'd0, buf_rdpointer}, 32'h0000);
    tick();
    chk("al.dvpulse", {31'd0, dvalid0}, 32'd0);

    // unaligned read by requester 1
    req1 = 1'b1; ptr1 = 16'h0013;
    tick();                                   // cycle 1
    chk("ua.gnt1", {31'd0, gnt1}, 32'd1);
    chk("ua.ptr1", {16'd0, buf_rdpointer}, 32'h0013);
    req1 = 1'b0;
    tick();                                   // cycle 2
    chk("ua.ptr2", {16'd0, buf_rdpointer}, 32'h0013);
    chk("ua.nodv", {30'd0, dvalid1, dvalid0}, 32'd0);
    tick();                                   // cycle 3
    chk("ua.ptr3", {16'd0, buf_rdpointer}, 32'h0013);
    buf_ovalid = 1'b1; buf_odata = 32'h55667788;
    tick();                                   // cycle 4
    buf_ovalid = 1'b0;
    chk("ua.dv1", {31'd0, dvalid1}, 32'd1);
    chk("ua.data1", data1, 32'h55667788);
    chk("ua.data0hold", data0, 32'hA1B2C3D4);
    tick();

    // contention: six grants alternate 0,1,0,1,0,1
    req0 = 1'b1; ptr0 = 16'h0020;
    req1 = 1'b1; ptr1 = 16'h0024;
    for (int g = 0; g < 6; g++) begin
      tick();                                 // cycle 1
      chk($sformatf("rr%0d.gnt", g), {30'd0, gnt1, gnt0}, (g % 2 == 0) ? 32'd1 : 32'd2);
      chk($sformatf("rr%0d.ptr", g), {16'd0, buf_rdpointer}, (g % 2 == 0) ? 32'h20 : 32'h24);
      tick();                                 // cycle 2
      buf_ovalid = 1'b1; buf_odata = 32'hC0DE0000 + g;
      tick();                                 // cycle 3
      buf_ovalid = 1'b0;
      if (g == 5) begin
        req0 = 1'b0; req1 = 1'b0;
      end
      chk($sformatf("rr%0d.dv", g), {30'd0, dvalid1, dvalid0}, (g % 2 == 0) ? 32'd1 : 32'd2);
      chk($sformatf("rr%0d.data", g), (g % 2 == 0) ? data0 : data1, 32'hC0DE0000 + g);
    end
    tick();
    chk("rr.idle", {30'd0, gnt1, gnt0}, 32'd0);

    // buffer clear during an unaligned read; requester 1 waits it out
    req0 = 1'b1; ptr0 = 16'h0031;
    tick();                                   // cycle 1
    chk("cl.gnt0", {31'd0, gnt0}, 32'd1);
    req0 = 1'b0;
    req1 = 1'b1; ptr1 = 16'h0040;
    tick();                                   // cycle 2
    buf_unable = 1'b1;
    tick();                                   // cycle 3
    chk("cl.abort", {31'd0, abort}, 32'd1);
    chk("cl.abid", {31'd0, abort_id}, 32'd0);
    chk("cl.nodv", {30'd0, dvalid1, dvalid0}, 32'd0);
    chk("cl.terr", {31'd0, timeout_err}, 32'd0);
    tick();                                   // cycle 4
    chk("cl.norq", {29'd0, buf_rdreq, gnt1, abort}, 32'd0);
    tick();                                   // cycle 5
    chk("cl.norq2", {30'd0, buf_rdreq, gnt1}, 32'd0);
    buf_unable = 1'b0;
    tick();                                   // cycle 6
    chk("cl.gnt1", {31'd0, gnt1}, 32'd1);
    chk("cl.rdreq", {31'd0, buf_rdreq}, 32'd1);
    chk("cl.ptr", {16'd0, buf_rdpointer}, 32'h0040);
    req1 = 1'b0;
    tick();
    buf_ovalid = 1'b1; buf_odata = 32'h0BADF00D;
    tick();
    buf_ovalid = 1'b0;
    chk("cl.dv1", {31'd0, dvalid1}, 32'd1);
    chk("cl.data1", data1, 32'h0BADF00D);
    tick();

    // timeout: no data ever returns
    req0 = 1'b1; ptr0 = 16'h0050;
    tick();                                   // cycle 1 (ISSUE)
    chk("to.gnt0", {31'd0, gnt0}, 32'd1);
    req0 = 1'b0;
    for (int c = 2; c <= 8; c++) begin
      tick();
      chk($sformatf("to.c%0d", c), {30'd0, abort, timeout_err}, 32'd0);
    end
    tick();                                   // cycle 9
    chk("to.abort", {31'd0, abort}, 32'd1);
    chk("to.abid", {31'd0, abort_id}, 32'd0);
    chk("to.terr", {31'd0, timeout_err}, 32'd1);
    chk("to.nodv", {30'd0, dvalid1, dvalid0}, 32'd0);
    req1 = 1'b1; ptr1 = 16'h0060;
    tick();
    chk("to.gnt1", {31'd0, gnt1}, 32'd1);
    req1 = 1'b0;
    tick();
    buf_ovalid = 1'b1; buf_odata = 32'h12345678;
    tick();
    buf_ovalid = 1'b0;
    chk("to.dv1", {31'd0, dvalid1}, 32'd1);
    chk("to.data1", data1, 32'h12345678);
    chk("to.sticky", {31'd0, timeout_err}, 32'd1);
    tick();

    // reset while waiting; late data is dropped and rr restarts at 0
    req1 = 1'b1; ptr1 = 16'h0070;
    tick();
    chk("rw.gnt1", {31'd0, gnt1}, 32'd1);
    req1 = 1'b0;
    tick();
    rstN = 1'b0;
    tick();
    chk_all_zero("rw");
    rstN = 1'b1;
    buf_ovalid = 1'b1; buf_odata = 32'hDEADBEEF;
    tick();
    buf_ovalid = 1'b0;
    tick();
    chk("rw.late", {30'd0, dvalid1, dvalid0}, 32'd0);
    chk("rw.data0", data0, 32'd0);
    chk("rw.data1", data1, 32'd0);
    req0 = 1'b1; ptr0 = 16'h0080;
    req1 = 1'b1; ptr1 = 16'h0084;
    tick();
    chk("rw.first", {30'd0, gnt1, gnt0}, 32'd1);
    chk("rw.ptr", {16'd0, buf_rdpointer}, 32'h0080);
    req0 = 1'b0; req1 = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
